// File: rtl/scsi_port_arb.sv
// SCSI port arbiter: one grant at a time (CPU or DMA), bounded DMA bursts, round-robin fairness.
// Optional watchdog is built only when ARB_WATCHDOG_EN is defined.
module scsi_port_arb #(
    parameter int MAXBURST   = 4,
    parameter int WDT_CYCLES = 255
) (
    input  logic       CPUCLK,
    input  logic       RESET,
    input  logic       CPUREQ,
    input  logic       DREQ_,
    input  logic       DMAENA,
    input  logic       DMADIR,
    input  logic       FIFOFULL,
    input  logic       FIFOEMPTY,
    input  logic       CYCDONE,
    output logic       CPUGNT,
    output logic       DMAGNT,
    output logic       GNTDIR,
    output logic [3:0] BURST,
    output logic       BUSY,
    output logic       TIMEOUT,
    output logic [1:0] dbg_state
);

    // Handshake: CPUREQ/DMAOK are levels held until served; a grant is released only
    // by a CYCDONE pulse (or the watchdog), and every release passes through GAP.
    typedef enum logic [1:0] {S_IDLE, S_CPU, S_DMA, S_GAP} state_t;

    localparam logic [4:0] MAXB = 5'(MAXBURST);

    state_t     state_q, state_d;
    logic       lastcpu_q, lastcpu_d;
    logic       gntdir_q, gntdir_d;
    logic [3:0] burst_q, burst_d;
    logic       cpugnt_q, cpugnt_d;
    logic       dmagnt_q, dmagnt_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       dmaok;
    logic [4:0] burst_next;
    logic       limit_hit;
    logic       wdt_fire;

    assign dmaok      = DMAENA & ~DREQ_ & (DMADIR ? ~FIFOEMPTY : ~FIFOFULL);
    assign burst_next = {1'b0, burst_q} + 5'd1;
    assign limit_hit  = CPUREQ & (burst_next >= MAXB);

`ifdef ARB_WATCHDOG_EN
    localparam int WDT_W = ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             in_grant;

    assign in_grant = (state_q == S_CPU) || (state_q == S_DMA);
    assign wdt_fire = in_grant && !CYCDONE && (wdt_q == WDT_LAST);

    // Clearing in IDLE covers every grant entry, since grants are only entered from IDLE.
    always_comb begin
        wdt_d = wdt_q;
        if (CYCDONE || state_q == S_IDLE) begin
            wdt_d = '0;
        end else if (in_grant) begin
            wdt_d = wdt_q + 1'b1;
        end
    end

    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    // No watchdog: grants wait for CYCDONE forever; WDT_CYCLES has no effect here.
    assign wdt_fire = 1'b0 & (WDT_CYCLES == 0);
`endif

    always_comb begin
        state_d   = state_q;
        lastcpu_d = lastcpu_q;
        gntdir_d  = gntdir_q;
        burst_d   = burst_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // On contention the requester not served last wins.
                if (CPUREQ && (!dmaok || !lastcpu_q)) begin
                    state_d   = S_CPU;
                    lastcpu_d = 1'b1;
                end else if (dmaok) begin
                    state_d   = S_DMA;
                    lastcpu_d = 1'b0;
                    burst_d   = 4'd0;
                    gntdir_d  = DMADIR;
                end
            end
            S_CPU: begin
                if (CYCDONE) begin
                    state_d = S_GAP;
                end else if (wdt_fire) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                end
            end
            S_DMA: begin
                if (CYCDONE) begin
                    burst_d = (burst_q == 4'd15) ? 4'd15 : burst_next[3:0];
                    if (!dmaok || limit_hit) begin
                        state_d = S_GAP;
                    end
                end else if (wdt_fire) begin
                    state_d   = S_GAP;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cpugnt_d = (state_d == S_CPU);
        dmagnt_d = (state_d == S_DMA);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge CPUCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            lastcpu_q <= 1'b0;
            gntdir_q  <= 1'b0;
            burst_q   <= 4'd0;
            cpugnt_q  <= 1'b0;
            dmagnt_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lastcpu_q <= lastcpu_d;
            gntdir_q  <= gntdir_d;
            burst_q   <= burst_d;
            cpugnt_q  <= cpugnt_d;
            dmagnt_q  <= dmagnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign CPUGNT    = cpugnt_q;
    assign DMAGNT    = dmagnt_q;
    assign GNTDIR    = gntdir_q;
    assign BURST     = burst_q;
    assign BUSY      = busy_q;
    assign TIMEOUT   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scsi_port_arb.sv
// Bench for scsi_port_arb: directed scenarios plus random traffic, all checked against
// a cycle model built from the arbitration rules (owner / gap / burst count).
module tb_scsi_port_arb;

    localparam int MAXB = 4;
    localparam int WDT  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpureq = 1'b0, dreq_n = 1'b1, dmaena = 1'b0, dmadir = 1'b0;
    logic       fifofull = 1'b0, fifoempty = 1'b0, cycdone = 1'b0;
    logic       cpugnt, dmagnt, gntdir, busy, timeout;
    logic [3:0] burst;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: who owns the port, whether we sit in the post-release gap,
    // how many DMA cycles this grant has done, and which side was served last.
    int m_owner;   // 0 none, 1 cpu, 2 dma
    bit m_gap;
    int m_burst;
    bit m_lastcpu;
    bit m_dir;
    bit m_timeout;
    int m_held;

    scsi_port_arb #(.MAXBURST(MAXB), .WDT_CYCLES(WDT)) dut (
        .CPUCLK(clk), .RESET(rst), .CPUREQ(cpureq), .DREQ_(dreq_n), .DMAENA(dmaena),
        .DMADIR(dmadir), .FIFOFULL(fifofull), .FIFOEMPTY(fifoempty), .CYCDONE(cycdone),
        .CPUGNT(cpugnt), .DMAGNT(dmagnt), .GNTDIR(gntdir), .BURST(burst), .BUSY(busy),
        .TIMEOUT(timeout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = 0; m_gap = 0; m_burst = 0; m_lastcpu = 0; m_dir = 0; m_timeout = 0; m_held = 0;
    endfunction

    function automatic void model_step();
        bit dmaok;
        bit fire;
        dmaok = dmaena && !dreq_n && (dmadir ? !fifoempty : !fifofull);
        m_timeout = 0;
        if (rst) begin
            model_reset();
        end else if (m_gap) begin
            m_gap = 0;
        end else if (m_owner == 0) begin
            m_held = 0;
            if (cpureq && dmaok) m_owner = m_lastcpu ? 2 : 1;
            else if (cpureq)     m_owner = 1;
            else if (dmaok)      m_owner = 2;
            if (m_owner == 1) m_lastcpu = 1;
            if (m_owner == 2) begin
                m_lastcpu = 0; m_burst = 0; m_dir = dmadir;
            end
        end else if (cycdone) begin
            m_held = 0;
            if (m_owner == 2) begin
                m_burst = (m_burst + 1 > 15) ? 15 : m_burst + 1;
                if (!dmaok || (cpureq && m_burst >= MAXB)) begin
                    m_owner = 0; m_gap = 1;
                end
            end else begin
                m_owner = 0; m_gap = 1;
            end
        end else begin
            m_held++;
            fire = 0;
`ifdef ARB_WATCHDOG_EN
            fire = (m_held == WDT);
`endif
            if (fire) begin
                m_owner = 0; m_gap = 1; m_timeout = 1;
            end
        end
    endfunction

    task automatic check_model();
        check_eq("cpugnt", cpugnt, m_owner == 1);
        check_eq("dmagnt", dmagnt, m_owner == 2);
        check_eq("busy", busy, (m_owner != 0) || m_gap);
        check_eq("gntdir", gntdir, m_dir);
        check_eq("burst", burst, m_burst);
        check_eq("timeout", timeout, m_timeout);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        cycdone = 1'b1;
        tick();
        cycdone = 1'b0;
    endtask

    task automatic dma_setup(input logic dir);
        dmaena = 1'b1; dreq_n = 1'b0; dmadir = dir; fifofull = 1'b0; fifoempty = 1'b0;
    endtask

    task automatic dma_off();
        dmaena = 1'b0; dreq_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int busy_cnt;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Reset while DMA owns the port: outputs drop before any clock edge
        dma_setup(1'b0);
        tick();
        check_eq("pre_reset_dmagnt", dmagnt, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("async_rst_dmagnt", dmagnt, 1'b0);
        check_eq("async_rst_cpugnt", cpugnt, 1'b0);
        check_eq("async_rst_busy", busy, 1'b0);
        check_eq("async_rst_burst", burst, 4'd0);
        check_eq("async_rst_gntdir", gntdir, 1'b0);
        check_eq("async_rst_timeout", timeout, 1'b0);
        @(negedge clk);
        tick(); tick(); tick();
        rst = 1'b0;
        dma_off();
        cpureq = 1'b1;
        tick();
        check_eq("post_reset_cpugnt", cpugnt, 1'b1);
        cpureq = 1'b0;
        pulse_done();
        tick();

        // CPU cycle: done 4 clocks after grant
        cpureq = 1'b1;
        cnt = 0; busy_cnt = 0;
        tick();
        for (int i = 0; i < 8; i++) begin
            if (cpugnt) cnt++;
            if (busy) busy_cnt++;
            if (i == 3) begin
                cpureq = 1'b0;
                pulse_done();
            end else begin
                tick();
            end
        end
        check_eq("cpu_gnt_len", cnt, 4);
        check_eq("cpu_busy_len", busy_cnt, 5);

        // DMA burst limit with CPU waiting
        dma_setup(1'b0);
        tick();
        check_eq("burst_dmagnt", dmagnt, 1'b1);
        cpureq = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20 && dmagnt; i++) begin
            tick();
            pulse_done();
            cnt++;
        end
        check_eq("burst_pulses", cnt, MAXB);
        check_eq("burst_val", burst, MAXB);
        check_eq("burst_drop", dmagnt, 1'b0);
        tick();
        tick();
        check_eq("cpu_after_burst", cpugnt, 1'b1);
        cpureq = 1'b0;
        dma_off();
        pulse_done();
        tick();

        // Unlimited DMA with no CPU request, burst saturates
        dma_setup(1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            pulse_done();
        end
        check_eq("unlim_dmagnt", dmagnt, 1'b1);
        check_eq("unlim_burst_sat", burst, 4'd15);
        dma_off();
        pulse_done();
        tick();

        // Eligibility loss mid-cycle and direction latch
        dma_setup(1'b1);
        tick();
        check_eq("dir_gntdir", gntdir, 1'b1);
        dmadir = 1'b0;
        tick();
        dmadir = 1'b1;
        fifoempty = 1'b1;
        tick();
        tick();
        check_eq("elig_hold", dmagnt, 1'b1);
        check_eq("dir_hold", gntdir, 1'b1);
        pulse_done();
        check_eq("elig_drop", dmagnt, 1'b0);
        dma_off();
        fifoempty = 1'b0;
        tick();
        tick();

        // CPU grant with no completion
        cpureq = 1'b1;
        cnt = 0;
        tick();
        for (int i = 0; i < 50; i++) begin
            if (timeout) cnt++;
            tick();
        end
`ifdef ARB_WATCHDOG_EN
        check_eq("wdt_timeouts", cnt > 0, 1'b1);
`else
        check_eq("hold_cpugnt", cpugnt, 1'b1);
        check_eq("hold_no_timeout", cnt, 0);
`endif
        cpureq = 1'b0;
        pulse_done();
        tick();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cpureq    = ($urandom_range(0, 3) != 0);
            dmaena    = ($urandom_range(0, 7) != 0);
            dreq_n    = ($urandom_range(0, 3) == 0);
            dmadir    = $urandom_range(0, 1);
            fifofull  = ($urandom_range(0, 4) == 0);
            fifoempty = ($urandom_range(0, 4) == 0);
            cycdone   = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        cycdone = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
